rps_dut: RTL and testbench
==========================

Name: rps_dut

Overview:
- Rock-paper-scissors referee for two players sharing one clock domain.
- Each player submits a move: a one-hot r/p/s vector qualified by a go pulse.
- Once both moves are captured, the block judges the round and increments the winner's running score.
- dut_busy tells the testbench clock/reset environment and drivers that a round is in progress.

Parameters:
- SCORE_W, 16, width of each player's score counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset. Low = reset asserted.
- r1  input  1  player 1 rock select.
- p1  input  1  player 1 paper select.
- s1  input  1  player 1 scissors select.
- go1  input  1  player 1 move-valid strobe; r1/p1/s1 are sampled when go1=1.
- r2  input  1  player 2 rock select.
- p2  input  1  player 2 paper select.
- s2  input  1  player 2 scissors select.
- go2  input  1  player 2 move-valid strobe.
- score1  output  SCORE_W  player 1 win count, registered.
- score2  output  SCORE_W  player 2 win count, registered.
- dut_busy  output  1  high while a round is open or being judged, registered.

Behaviour:
- Reset (rst=0, async): state=IDLE, score1=0, score2=0, dut_busy=0, captured moves cleared. Release is synchronous to the next clk edge.
- Move decode:
  - Exactly one of r/p/s high = valid move ROCK/PAPER/SCISSORS.
  - Zero or multiple bits high = INVALID.
- FSM states: IDLE, WAIT1 (holding P1 move, waiting for P2), WAIT2 (holding P2 move, waiting for P1), JUDGE.
- IDLE:
  - go1&go2 in the same cycle: capture both, go to JUDGE.
  - Only go1: capture P1, go to WAIT1.
  - Only go2: capture P2, go to WAIT2.
- WAIT1: go2 captures P2 and goes to JUDGE. Further go1 pulses are ignored; the first move stands.
- WAIT2: mirror of WAIT1.
- JUDGE: lasts one cycle, updates scores, returns to IDLE. go1/go2 arriving during JUDGE are ignored and are not queued.
- dut_busy = 1 in WAIT1, WAIT2, JUDGE; 0 in IDLE. It is a registered output derived from next-state.
- Latency:
  - If the second go is sampled at edge N, dut_busy=1 after edge N.
  - Score updates at edge N+1; dut_busy=0 after edge N+1.
  - A new round may start at edge N+2.
- Judging:
  - ROCK beats SCISSORS, SCISSORS beats PAPER, PAPER beats ROCK.
  - Identical valid moves = draw, no score change.
  - A valid move beats an INVALID move.
  - Both INVALID = draw.
- Score arithmetic: the winner's score increments by 1. At 2^SCORE_W-1 it saturates; there is no wrap. Only one score changes per round.
- Reset mid-round discards captured moves and zeroes the scores immediately.
- Inputs r/p/s are ignored unless their go strobe is high.

Decomposition:
- Package rps_pkg holds:
  - typedef enum move_t {NONE, ROCK, PAPER, SCISSORS, INVALID}.
  - typedef enum result_t {DRAW, P1_WINS, P2_WINS}.
  - typedef enum state_t {IDLE, WAIT1, WAIT2, JUDGE}.
  - Function decode_move(r,p,s) returning move_t.
- One combinational sub-module, rps_judge: inputs move1 and move2 (move_t), output result_t.
- rps_dut holds the FSM, the move capture registers and the score counters.

Test Plan:
- Reset check: hold rst=0 mid-run, then release. Required: score1=0, score2=0, dut_busy=0, with no clk edge needed for the outputs to clear.
- Simultaneous valid moves: go1&go2 with r1=1, s2=1. Required: score1=1, score2=0 one cycle later; dut_busy high for exactly 1 cycle.
- Staggered moves with draw: go1 with p1=1, then 3 idle cycles, then go2 with p2=1. Required: dut_busy high from the cycle after go1 until after JUDGE; scores unchanged.
- Repeated strobe and ignored-during-JUDGE:
  - go1 with s1=1, then go1 with r1=1, then go2 with p2=1. Required: the first move holds, P1 wins, score1 +1.
  - go1/go2 pulsed during JUDGE. Required: no effect.
- Invalid move: go1 with r1=p1=1 and go2 with s2=1. Required: score2 +1. With both moves invalid: no change.
- Saturation: with SCORE_W=4, play 16 rounds won by P2. Required: score2 stops at 15.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors referee.
// Move encoding, round result, FSM states and the move decoder.
package rps_pkg;

    typedef enum logic [2:0] {
        NONE,
        ROCK,
        PAPER,
        SCISSORS,
        INVALID
    } move_t;

    typedef enum logic [1:0] {
        DRAW,
        P1_WINS,
        P2_WINS
    } result_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT1,
        WAIT2,
        JUDGE
    } state_t;

    // Exactly one select bit gives a real move; anything else is invalid.
    function automatic move_t decode_move(
        input logic r,
        input logic p,
        input logic s
    );
        move_t m;
        case ({r, p, s})
            3'b100:  m = ROCK;
            3'b010:  m = PAPER;
            3'b001:  m = SCISSORS;
            default: m = INVALID;
        endcase
        return m;
    endfunction

    function automatic logic is_valid(input move_t m);
        return (m == ROCK) || (m == PAPER) || (m == SCISSORS);
    endfunction

endpackage

// File: rtl/rps_if.sv
// Player move inputs and score/busy outputs of the referee.
// The bench drives through master, the referee sits on slave.
interface rps_if #(
    parameter int SCORE_W = 16
);
    logic               r1;
    logic               p1;
    logic               s1;
    logic               go1;
    logic               r2;
    logic               p2;
    logic               s2;
    logic               go2;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               dut_busy;

    modport master (
        output r1, p1, s1, go1,
        output r2, p2, s2, go2,
        input  score1, score2, dut_busy
    );

    modport slave (
        input  r1, p1, s1, go1,
        input  r2, p2, s2, go2,
        output score1, score2, dut_busy
    );
endinterface

// File: rtl/rps_judge.sv
// Combinational round judge.
// A valid move beats an invalid one; two non-moves draw.
module rps_judge
    import rps_pkg::*;
(
    input  move_t   move1,
    input  move_t   move2,
    output result_t result
);

    logic v1;
    logic v2;
    logic p1_beats;

    assign v1 = is_valid(move1);
    assign v2 = is_valid(move2);

    assign p1_beats = (move1 == ROCK     && move2 == SCISSORS) ||
                      (move1 == SCISSORS && move2 == PAPER)    ||
                      (move1 == PAPER    && move2 == ROCK);

    // Pick the winner from validity first, then the beats relation.
    always_comb begin
        result = DRAW;
        if (v1 && !v2) begin
            result = P1_WINS;
        end else if (!v1 && v2) begin
            result = P2_WINS;
        end else if (v1 && v2 && (move1 != move2)) begin
            result = p1_beats ? P1_WINS : P2_WINS;
        end
    end

endmodule

// File: rtl/rps_dut.sv
// Rock-paper-scissors referee: move capture FSM and saturating scores.
// Busy is registered from next-state so it rises with the capturing edge.
module rps_dut
    import rps_pkg::*;
#(
    parameter int SCORE_W = 16
) (
    input  logic  clk,
    input  logic  rst,
    rps_if.slave  bus
);

    localparam logic [SCORE_W-1:0] ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    state_t             state_d;
    move_t              mv1_q;
    move_t              mv1_d;
    move_t              mv2_q;
    move_t              mv2_d;
    logic [SCORE_W-1:0] score1_q;
    logic [SCORE_W-1:0] score1_d;
    logic [SCORE_W-1:0] score2_q;
    logic [SCORE_W-1:0] score2_d;
    logic               busy_q;
    move_t              m1_in;
    move_t              m2_in;
    result_t            result;

    assign m1_in = decode_move(bus.r1, bus.p1, bus.s1);
    assign m2_in = decode_move(bus.r2, bus.p2, bus.s2);

    rps_judge u_judge (
        .move1  (mv1_q),
        .move2  (mv2_q),
        .result (result)
    );

    // State, captured moves, scores and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mv1_q    <= NONE;
            mv2_q    <= NONE;
            score1_q <= '0;
            score2_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mv1_q    <= mv1_d;
            mv2_q    <= mv2_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Next state: capture first move per player, judge once both are in.
    always_comb begin
        state_d  = state_q;
        mv1_d    = mv1_q;
        mv2_d    = mv2_q;
        score1_d = score1_q;
        score2_d = score2_q;
        unique case (state_q)
            IDLE: begin
                if (bus.go1 && bus.go2) begin
                    mv1_d   = m1_in;
                    mv2_d   = m2_in;
                    state_d = JUDGE;
                end else if (bus.go1) begin
                    mv1_d   = m1_in;
                    state_d = WAIT1;
                end else if (bus.go2) begin
                    mv2_d   = m2_in;
                    state_d = WAIT2;
                end
            end
            WAIT1: begin
                if (bus.go2) begin
                    mv2_d   = m2_in;
                    state_d = JUDGE;
                end
            end
            WAIT2: begin
                if (bus.go1) begin
                    mv1_d   = m1_in;
                    state_d = JUDGE;
                end
            end
            JUDGE: begin
                if (result == P1_WINS && score1_q != '1) begin
                    score1_d = score1_q + ONE;
                end
                if (result == P2_WINS && score2_q != '1) begin
                    score2_d = score2_q + ONE;
                end
                mv1_d   = NONE;
                mv2_d   = NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.score1   = score1_q;
    assign bus.score2   = score2_q;
    assign bus.dut_busy = busy_q;

endmodule

// File: tb/tb_rps_dut.sv
// Self-checking bench for the rock-paper-scissors referee.
// Table of simultaneous rounds plus directed multi-cycle sequences.
module tb_rps_dut;

    localparam int W = 4;

    typedef struct {
        logic [2:0] rps1;
        logic [2:0] rps2;
        int         d1;
        int         d2;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   e1;
    int   e2;
    vec_t tbl[12];

    rps_if #(.SCORE_W(W)) bus ();

    rps_dut #(.SCORE_W(W)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input logic go, input logic [2:0] m);
        bus.go1 = go;
        {bus.r1, bus.p1, bus.s1} = m;
    endtask

    task automatic set2(input logic go, input logic [2:0] m);
        bus.go2 = go;
        {bus.r2, bus.p2, bus.s2} = m;
    endtask

    task automatic idle();
        set1(1'b0, 3'b000);
        set2(1'b0, 3'b000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // rock=100 paper=010 scissors=001
        tbl[0]  = '{3'b100, 3'b001, 1, 0};
        tbl[1]  = '{3'b100, 3'b010, 0, 1};
        tbl[2]  = '{3'b100, 3'b100, 0, 0};
        tbl[3]  = '{3'b010, 3'b100, 1, 0};
        tbl[4]  = '{3'b010, 3'b001, 0, 1};
        tbl[5]  = '{3'b001, 3'b010, 1, 0};
        tbl[6]  = '{3'b001, 3'b100, 0, 1};
        tbl[7]  = '{3'b001, 3'b001, 0, 0};
        tbl[8]  = '{3'b110, 3'b001, 0, 1};
        tbl[9]  = '{3'b000, 3'b000, 0, 0};
        tbl[10] = '{3'b100, 3'b111, 1, 0};
        tbl[11] = '{3'b110, 3'b011, 0, 0};

        rst_n = 1'b0;
        idle();
        #12;
        check("reset_score1", int'(bus.score1), 0);
        check("reset_score2", int'(bus.score2), 0);
        check("reset_busy", int'(bus.dut_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Selects without go must be ignored.
        set1(1'b0, 3'b100);
        set2(1'b0, 3'b001);
        tick();
        tick();
        check("nogo_busy", int'(bus.dut_busy), 0);
        check("nogo_score1", int'(bus.score1), 0);
        idle();

        e1 = 0;
        e2 = 0;
        for (int i = 0; i < 12; i++) begin
            set1(1'b1, tbl[i].rps1);
            set2(1'b1, tbl[i].rps2);
            tick();
            check($sformatf("tbl%0d_busy_hi", i), int'(bus.dut_busy), 1);
            check($sformatf("tbl%0d_hold_s1", i), int'(bus.score1), e1);
            idle();
            tick();
            e1 += tbl[i].d1;
            e2 += tbl[i].d2;
            check($sformatf("tbl%0d_score1", i), int'(bus.score1), e1);
            check($sformatf("tbl%0d_score2", i), int'(bus.score2), e2);
            check($sformatf("tbl%0d_busy_lo", i), int'(bus.dut_busy), 0);
        end

        // Staggered paper vs paper: busy spans the wait, draw.
        set1(1'b1, 3'b010);
        tick();
        check("stag_busy_w1", int'(bus.dut_busy), 1);
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stag_busy_wait%0d", k), int'(bus.dut_busy), 1);
        end
        set2(1'b1, 3'b010);
        tick();
        check("stag_busy_judge", int'(bus.dut_busy), 1);
        idle();
        tick();
        check("stag_busy_done", int'(bus.dut_busy), 0);
        check("stag_score1", int'(bus.score1), e1);
        check("stag_score2", int'(bus.score2), e2);

        // First move stands; strobes during JUDGE are dropped.
        set1(1'b1, 3'b001);
        tick();
        set1(1'b1, 3'b100);
        tick();
        set1(1'b0, 3'b000);
        set2(1'b1, 3'b010);
        tick();
        check("rep_busy", int'(bus.dut_busy), 1);
        set1(1'b1, 3'b100);
        set2(1'b1, 3'b001);
        tick();
        e1 += 1;
        check("rep_score1", int'(bus.score1), e1);
        check("rep_score2", int'(bus.score2), e2);
        check("rep_busy_lo", int'(bus.dut_busy), 0);
        idle();
        tick();
        tick();
        check("judge_ign_busy", int'(bus.dut_busy), 0);
        check("judge_ign_s1", int'(bus.score1), e1);
        check("judge_ign_s2", int'(bus.score2), e2);

        // Async reset in WAIT1 clears outputs without an edge.
        set1(1'b1, 3'b100);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_score1", int'(bus.score1), 0);
        check("mid_rst_score2", int'(bus.score2), 0);
        check("mid_rst_busy", int'(bus.dut_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Old P1 move must be gone: lone go2 waits for P1.
        set2(1'b1, 3'b010);
        tick();
        idle();
        tick();
        check("post_rst_wait", int'(bus.dut_busy), 1);
        check("post_rst_s2", int'(bus.score2), 0);
        set1(1'b1, 3'b100);
        tick();
        idle();
        tick();
        check("post_rst_s1", int'(bus.score1), 0);
        check("post_rst_win2", int'(bus.score2), 1);

        // Saturation: P2 wins 16 rounds on a 4-bit counter.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            set1(1'b1, 3'b100);
            set2(1'b1, 3'b010);
            tick();
            idle();
            tick();
            check($sformatf("sat_r%0d", i), int'(bus.score2), (i > 15) ? 15 : i);
        end
        check("sat_score1", int'(bus.score1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
